// File: rtl/sodor_scratchpad_mem.sv
// Sodor single-ported scratchpad with one-cycle response.
// Byte/half/word access, lane masking, load extension, error flag.
module sodor_scratchpad_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 65536
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        io_req_valid,
  input  logic [31:0] io_req_bits_addr,
  input  logic [31:0] io_req_bits_data,
  input  logic        io_req_bits_fcn,
  input  logic [2:0]  io_req_bits_typ,
  output logic        io_resp_valid,
  output logic [31:0] io_resp_bits_data,
  output logic [31:0] io_resp_addr,
  output logic        io_resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] WIN = 33'(DEPTH_WORDS) << 2;

  logic [31:0] mem [DEPTH_WORDS];

  logic [32:0]   offs;
  logic          inWin;
  logic [AW-1:0] wordIdx;
  logic [1:0]    byteOff;
  logic          misAlign;
  logic          badTyp;
  logic          reqErr;
  logic [3:0]    byteEn;
  logic [31:0]   wrData;
  logic          doWrite;

  logic        pValid;
  logic        pFcn;
  logic [2:0]  pTyp;
  logic [31:0] pAddr;
  logic        pErr;
  logic [31:0] rdWord;
  logic [31:0] shWord;
  logic [31:0] extData;

  // Wrap below the base lands in bit 32, so it reads out of window.
  assign offs    = {1'b0, io_req_bits_addr} - {1'b0, BASE_ADDR};
  assign inWin   = offs < WIN;
  assign wordIdx = offs[AW+1:2];
  assign byteOff = io_req_bits_addr[1:0];

  // Alignment and typ legality.
  always_comb begin
    misAlign = 1'b0;
    badTyp   = 1'b0;
    case (io_req_bits_typ)
      3'd1, 3'd5: misAlign = 1'b0;
      3'd2, 3'd6: misAlign = byteOff[0];
      3'd3, 3'd7: misAlign = |byteOff;
      default:    badTyp   = 1'b1;
    endcase
  end

  assign reqErr  = !inWin || misAlign || badTyp;
  assign doWrite = io_req_valid && io_req_bits_fcn && !reqErr;

  // Store lane replication and byte enables.
  always_comb begin
    byteEn = 4'b0000;
    wrData = io_req_bits_data;
    case (io_req_bits_typ[1:0])
      2'd1: begin
        byteEn = 4'b0001 << byteOff;
        wrData = {4{io_req_bits_data[7:0]}};
      end
      2'd2: begin
        byteEn = byteOff[1] ? 4'b1100 : 4'b0011;
        wrData = {2{io_req_bits_data[15:0]}};
      end
      2'd3: byteEn = 4'b1111;
      default: byteEn = 4'b0000;
    endcase
  end

  // Array write; contents are never reset, writes gated by reset.
  always_ff @(posedge clock) begin
    if (reset_n && doWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) begin
          mem[wordIdx][b*8 +: 8] <= wrData[b*8 +: 8];
        end
      end
    end
  end

  // Pending request; fields hold across idle cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pValid <= 1'b0;
      pFcn   <= 1'b0;
      pTyp   <= 3'd0;
      pAddr  <= 32'd0;
      pErr   <= 1'b0;
      rdWord <= 32'd0;
    end else begin
      pValid <= io_req_valid;
      if (io_req_valid) begin
        pFcn   <= io_req_bits_fcn;
        pTyp   <= io_req_bits_typ;
        pAddr  <= io_req_bits_addr;
        pErr   <= reqErr;
        rdWord <= mem[wordIdx];
      end
    end
  end

  assign shWord = rdWord >> {pAddr[1:0], 3'b000};

  // Lane extension from the registered typ.
  always_comb begin
    extData = 32'd0;
    case (pTyp)
      3'd1: extData = {{24{shWord[7]}}, shWord[7:0]};
      3'd5: extData = {24'd0, shWord[7:0]};
      3'd2: extData = {{16{shWord[15]}}, shWord[15:0]};
      3'd6: extData = {16'd0, shWord[15:0]};
      3'd3, 3'd7: extData = rdWord;
      default: extData = 32'd0;
    endcase
  end

  assign io_resp_valid     = pValid;
  assign io_resp_addr      = pAddr;
  assign io_resp_err       = pErr;
  assign io_resp_bits_data = (pFcn || pErr) ? 32'd0 : extData;

endmodule
